// File: rtl/matmul_sched_pkg.sv
// Shared types and sizing for the sigma·J·sigma sequencer.
package matmul_pkg;
    localparam int VECTOR_SIZE     = 256;
    localparam int J_COLS_PER_READ = 4;
    localparam int NUM_J_CHUNKS    = VECTOR_SIZE / J_COLS_PER_READ;
    localparam int ENERGY_WIDTH    = 2 * $clog2(VECTOR_SIZE) + 5;
    localparam int MEM_LATENCY     = 2;
    localparam int DP_LATENCY      = 74;
    localparam int ADDR_WIDTH      = (NUM_J_CHUNKS > 1) ? $clog2(NUM_J_CHUNKS) : 1;

    // One counter width serves both the start delay and the datapath wait.
    localparam int LAT_MAX     = (MEM_LATENCY > DP_LATENCY) ? MEM_LATENCY : DP_LATENCY;
    localparam int TIMER_WIDTH = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} sched_state_e;
    typedef logic signed [ENERGY_WIDTH-1:0] energy_t;
endpackage

// File: rtl/matmul_sched_if.sv
// Command, J-memory, datapath and result signals of the sequencer.
interface matmul_sched_if;
    import matmul_pkg::*;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [VECTOR_SIZE-1:0] cmd_sigma;
    energy_t                cmd_energy_prev;
    logic                   abort;
    logic                   mem_rd_en;
    logic [ADDR_WIDTH-1:0]  mem_rd_addr;
    logic                   dp_start;
    logic [VECTOR_SIZE-1:0] dp_sigma;
    energy_t                dp_energy;
    logic                   res_valid;
    logic                   res_ready;
    energy_t                res_energy;
    logic                   res_accept;
    logic                   busy;

    modport slave (
        input  cmd_valid, cmd_sigma, cmd_energy_prev, abort, dp_energy, res_ready,
        output cmd_ready, mem_rd_en, mem_rd_addr, dp_start, dp_sigma,
               res_valid, res_energy, res_accept, busy
    );

    modport master (
        output cmd_valid, cmd_sigma, cmd_energy_prev, abort, dp_energy, res_ready,
        input  cmd_ready, mem_rd_en, mem_rd_addr, dp_start, dp_sigma,
               res_valid, res_energy, res_accept, busy
    );
endinterface

// File: rtl/matmul_sched_timer.sv
// Loadable down-counter; expire marks the cycle whose edge steps the count to zero.
module matmul_sched_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = en && (cnt == W'(1));
endmodule

// File: rtl/matmul_sched.sv
// Sequences J-chunk reads, datapath start and energy capture for one sigma per command.
module matmul_sched
    import matmul_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    matmul_sched_if.slave  bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_J_CHUNKS - 1);

    sched_state_e           state, state_n;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [VECTOR_SIZE-1:0] sigma_q;
    energy_t                prev_q, res_energy_q;
    logic                   res_valid_q, res_accept_q;
    logic                   abort_hit, start_fire, dp_fire, capture, accept;

    assign abort_hit = bus.abort && (state == FETCH || state == WAIT);

    // Armed on the addr-0 read so dp_start trails it by exactly MEM_LATENCY.
    matmul_sched_timer #(.W(TIMER_WIDTH)) u_start_tmr (
        .clk      (clk),
        .rst      (rst),
        .clr      (abort_hit),
        .load     (state == FETCH && addr_q == '0),
        .load_val (TIMER_WIDTH'(MEM_LATENCY)),
        .en       (1'b1),
        .expire   (start_fire)
    );

    matmul_sched_timer #(.W(TIMER_WIDTH)) u_dp_tmr (
        .clk      (clk),
        .rst      (rst),
        .clr      (abort_hit),
        .load     (start_fire),
        .load_val (TIMER_WIDTH'(DP_LATENCY)),
        .en       (1'b1),
        .expire   (dp_fire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE:  if (bus.cmd_valid) begin
                       accept  = 1'b1;
                       state_n = FETCH;
                   end
            FETCH: if (bus.abort)               state_n = IDLE;
                   else if (addr_q == LAST_ADDR) state_n = WAIT;
            WAIT:  if (bus.abort) state_n = IDLE;
                   else if (dp_fire) begin
                       capture = 1'b1;
                       state_n = DONE;
                   end
            DONE:  if (bus.res_ready) state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            sigma_q      <= '0;
            prev_q       <= '0;
            res_energy_q <= '0;
            res_accept_q <= 1'b0;
            res_valid_q  <= 1'b0;
        end else begin
            if (accept) begin
                sigma_q <= bus.cmd_sigma;
                prev_q  <= bus.cmd_energy_prev;
                addr_q  <= '0;
            end else if (state == FETCH && addr_q != LAST_ADDR) begin
                addr_q <= addr_q + 1'b1;
            end
            if (capture) begin
                res_energy_q <= bus.dp_energy;
                res_accept_q <= bus.dp_energy < prev_q;
                res_valid_q  <= 1'b1;
            end else if (state == DONE && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    // cmd_ready is gated by rst so nothing is offered while reset is held.
    assign bus.cmd_ready   = (state == IDLE) && !rst;
    assign bus.mem_rd_en   = (state == FETCH);
    assign bus.mem_rd_addr = addr_q;
    assign bus.dp_start    = start_fire;
    assign bus.dp_sigma    = sigma_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_energy  = res_energy_q;
    assign bus.res_accept  = res_accept_q;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_matmul_sched.sv
// Randomized scoreboard bench for matmul_sched with a behavioural datapath model.
module tb_matmul_sched;
    import matmul_pkg::*;

    localparam int RES_LAT = 1 + MEM_LATENCY + DP_LATENCY;

    typedef struct {
        logic [VECTOR_SIZE-1:0] sigma;
        int                     energy;
        int                     prev;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   final_e = 0;
    exp_t sb[$];

    matmul_sched_if bus ();
    matmul_sched dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [VECTOR_SIZE-1:0] rand_sigma();
        logic [VECTOR_SIZE-1:0] s;
        for (int i = 0; i < VECTOR_SIZE / 32; i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    function automatic int rand_energy();
        return int'($urandom_range(0, (1 << ENERGY_WIDTH) - 1)) - (1 << (ENERGY_WIDTH - 1));
    endfunction

    function automatic energy_t junk();
        return energy_t'(final_e ^ int'($urandom_range(1, 1000)));
    endfunction

    // Datapath model: final energy valid only at the edge DP_LATENCY after dp_start.
    int ecnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            ecnt = 0;
            bus.dp_energy = '0;
        end else if (bus.dp_start) begin
            ecnt = DP_LATENCY;
            bus.dp_energy = junk();
        end else if (ecnt > 0) begin
            ecnt--;
            bus.dp_energy = (ecnt == 0) ? energy_t'(final_e) : junk();
        end else begin
            bus.dp_energy = junk();
        end
    end

    // Monitor / scoreboard
    int                     cur_acc = 0;
    bit                     active = 0, res_prev = 0, drop_pend = 0;
    energy_t                held_e;
    logic                   held_a;
    logic [VECTOR_SIZE-1:0] exp_sigma = '0;
    exp_t                   cur;

    always @(negedge clk) begin
        if (rst) begin
            active    = 0;
            res_prev  = 0;
            drop_pend = 0;
            exp_sigma = '0;
        end else begin
            chk("dp_sigma", bus.dp_sigma == exp_sigma, 1);
            if (active) begin
                chk("mem_rd_en", bus.mem_rd_en, (cyc - cur_acc) < NUM_J_CHUNKS);
                if (bus.mem_rd_en) chk("mem_rd_addr", bus.mem_rd_addr, cyc - cur_acc);
            end else begin
                chk("mem_rd_en_idle", bus.mem_rd_en, 0);
            end
            chk("dp_start", bus.dp_start, active && (cyc == cur_acc + MEM_LATENCY));
            if (drop_pend) begin
                chk("res_valid_drop", bus.res_valid, 0);
                chk("cmd_ready_after", bus.cmd_ready, 1);
                drop_pend = 0;
            end
            if (bus.res_valid && !res_prev) begin
                chk("res_latency", active ? cyc - cur_acc : -1, RES_LAT);
                if (sb.size() == 0) begin
                    chk("res_unexpected", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    chk("res_energy", $signed(bus.res_energy), cur.energy);
                    chk("res_accept", bus.res_accept, cur.energy < cur.prev);
                    chk("res_sigma", bus.dp_sigma == cur.sigma, 1);
                end
                held_e = bus.res_energy;
                held_a = bus.res_accept;
            end else if (bus.res_valid) begin
                chk("res_energy_hold", $signed(bus.res_energy), held_e);
                chk("res_accept_hold", bus.res_accept, held_a);
                chk("cmd_ready_done", bus.cmd_ready, 0);
            end
            if (bus.res_valid && bus.res_ready) begin
                drop_pend = 1;
                active    = 0;
            end
            if (bus.abort && bus.busy && !bus.res_valid) active = 0;
            if (bus.cmd_valid && bus.cmd_ready) begin
                cur_acc   = cyc + 1;
                active    = 1;
                exp_sigma = bus.cmd_sigma;
            end
            res_prev = bus.res_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int e, input int p, input bit push);
        int n = 0;
        logic [VECTOR_SIZE-1:0] s;
        while (!bus.cmd_ready && n < 300) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", bus.cmd_ready, 1);
        s = rand_sigma();
        bus.cmd_valid       = 1'b1;
        bus.cmd_sigma       = s;
        bus.cmd_energy_prev = energy_t'(p);
        final_e             = e;
        if (push) sb.push_back('{s, e, p});
        tick();
        bus.cmd_valid       = 1'b0;
        bus.cmd_sigma       = rand_sigma();
        bus.cmd_energy_prev = energy_t'(rand_energy());
    endtask

    initial begin
        bus.cmd_valid       = 1'b0;
        bus.cmd_sigma       = '0;
        bus.cmd_energy_prev = '0;
        bus.abort           = 1'b0;
        bus.res_ready       = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mem_rd_en", bus.mem_rd_en, 0);
        chk("rst_mem_rd_addr", bus.mem_rd_addr, 0);
        chk("rst_dp_start", bus.dp_start, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_energy", bus.res_energy, 0);
        chk("rst_res_accept", bus.res_accept, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("cmd_ready_post_reset", bus.cmd_ready, 1);

        // Reset in the middle of the fetch burst
        issue(rand_energy(), rand_energy(), 1'b0);
        repeat (17) tick();
        chk("pre_reset_addr", bus.mem_rd_addr, 17);
        rst = 1'b1;
        #1;
        chk("midrst_mem_rd_en", bus.mem_rd_en, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_res_valid", bus.res_valid, 0);
        chk("midrst_cmd_ready", bus.cmd_ready, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("cmd_ready_post_midrst", bus.cmd_ready, 1);

        for (int i = 0; i < 24; i++) begin
            automatic int e   = rand_energy();
            automatic int p   = ($urandom_range(0, 4) == 0) ? e : rand_energy();
            automatic bit b2b = (i >= 16);
            automatic bit ab  = (i == 3) || (i > 4 && i < 16 && $urandom_range(0, 3) == 0);
            if (i == 0) begin e = -100; p = -50; end
            if (i == 1) begin e = -50;  p = -50; end
            bus.res_ready = b2b;
            issue(e, p, !ab);
            if (ab) begin
                automatic int d = (i == 3) ? 30 : $urandom_range(0, 70);
                repeat (d) tick();
                if (i == 3) chk("abort_addr", bus.mem_rd_addr, 30);
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
                chk("abort_mem_rd_en", bus.mem_rd_en, 0);
                chk("abort_busy", bus.busy, 0);
                repeat (RES_LAT + 10) tick();
            end else if (!b2b) begin
                automatic int n     = 0;
                automatic int stall = (i == 2) ? 10 : $urandom_range(0, 4);
                while (!bus.res_valid && n < 300) begin
                    tick();
                    n++;
                end
                chk("res_valid_wait", bus.res_valid, 1);
                repeat (stall) begin
                    bus.cmd_valid = 1'($urandom_range(0, 1));
                    bus.cmd_sigma = rand_sigma();
                    tick();
                end
                bus.cmd_valid = 1'b0;
                bus.res_ready = 1'b1;
                tick();
                bus.res_ready = 1'b0;
            end
        end

        repeat (RES_LAT + 20) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
